// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: grants one functional-unit response per cycle
// and broadcasts the winner's payload, registered, for exactly one cycle.
module cdb_arbiter #(
    parameter int XLEN    = 32,
    parameter int NUM_REQ = 4,
    parameter int ROB_W   = 5,
    parameter int ARCH_W  = 5,
    parameter int PHYS_W  = 6,
    localparam int SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*XLEN-1:0]   req_value,
    input  logic [NUM_REQ*ARCH_W-1:0] req_rd,
    input  logic [NUM_REQ*PHYS_W-1:0] req_pd,
    input  logic [NUM_REQ*ROB_W-1:0]  req_rob_idx,
    input  logic [NUM_REQ-1:0]        req_dest_we,
    output logic                      cdb_valid,
    output logic [XLEN-1:0]           cdb_value,
    output logic [ARCH_W-1:0]         cdb_rd,
    output logic [PHYS_W-1:0]         cdb_pd,
    output logic [ROB_W-1:0]          cdb_rob_idx,
    output logic                      cdb_dest_we,
    output logic [SRC_W-1:0]          cdb_src
);

    logic [SRC_W-1:0]  ptr;
    logic              grant_any;
    logic [SRC_W-1:0]  grant_idx;
    int                idx;

    logic              vld_p1;
    logic              we_p1;
    logic [XLEN-1:0]   value_p1;
    logic [ARCH_W-1:0] rd_p1;
    logic [PHYS_W-1:0] pd_p1;
    logic [ROB_W-1:0]  rob_p1;
    logic [SRC_W-1:0]  src_p1;

    // Stage p0: combinational round-robin search starting at ptr
    always_comb begin
        req_ready = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        if (!rst && !flush) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (int'(ptr) + k) % NUM_REQ;
                if (!grant_any && req_valid[idx]) begin
                    grant_any = 1'b1;
                    grant_idx = SRC_W'(idx);
                end
            end
            if (grant_any) begin
                req_ready[grant_idx] = 1'b1;
            end
        end
    end

    // Stage p1: registered broadcast; payload holds when there is no grant
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            vld_p1   <= 1'b0;
            we_p1    <= 1'b0;
            value_p1 <= '0;
            rd_p1    <= '0;
            pd_p1    <= '0;
            rob_p1   <= '0;
            src_p1   <= '0;
        end else begin
            vld_p1 <= grant_any;
            we_p1  <= grant_any & req_dest_we[grant_idx];
            if (grant_any) begin
                value_p1 <= req_value[grant_idx*XLEN +: XLEN];
                rd_p1    <= req_rd[grant_idx*ARCH_W +: ARCH_W];
                pd_p1    <= req_pd[grant_idx*PHYS_W +: PHYS_W];
                rob_p1   <= req_rob_idx[grant_idx*ROB_W +: ROB_W];
                src_p1   <= grant_idx;
                ptr      <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    assign cdb_valid   = vld_p1;
    assign cdb_dest_we = we_p1;
    assign cdb_value   = value_p1;
    assign cdb_rd      = rd_p1;
    assign cdb_pd      = pd_p1;
    assign cdb_rob_idx = rob_p1;
    assign cdb_src     = src_p1;

    a_ready_onehot0: assert property (@(posedge clk) $onehot0(req_ready));
    a_ready_valid:   assert property (@(posedge clk) (req_ready & ~req_valid) == '0);
    a_we_valid:      assert property (@(posedge clk) disable iff (rst) cdb_dest_we |-> cdb_valid);

endmodule
